coco_sd_arbiter: RTL and testbench



---
 rtl/coco_sd_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_coco_sd_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/coco_sd_arbiter.sv
// Round-robin arbiter that shares the user_io SD block channel between the
// floppy controller (requester A) and the hard-disk/SDC interface (requester B).
module coco_sd_arbiter #(
    parameter int          NA      = 4,
    parameter int          NB      = 2,
    parameter logic [23:0] TIMEOUT = 24'd5_727_270
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [31:0]      a_lba,
    input  logic [NA-1:0]    a_rd,
    input  logic [NA-1:0]    a_wr,
    output logic             a_ack,
    output logic             a_buff_wr,
    input  logic [7:0]       a_buff_din,
    input  logic [31:0]      b_lba,
    input  logic [NB-1:0]    b_rd,
    input  logic [NB-1:0]    b_wr,
    output logic             b_ack,
    output logic             b_buff_wr,
    input  logic [7:0]       b_buff_din,
    output logic [31:0]      sd_lba,
    output logic [NA+NB-1:0] sd_rd,
    output logic [NA+NB-1:0] sd_wr,
    input  logic             sd_ack,
    input  logic             sd_buff_wr,
    output logic [7:0]       sd_buff_din,
    output logic [1:0]       grant,
    output logic             busy,
    output logic             timeout_err
);

    localparam int ND = NA + NB;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_XFER    = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    state_t          r_state;
    logic            r_last_b;
    logic [23:0]     r_cnt;
    logic [31:0]     r_lba;
    logic [ND-1:0]   r_rd;
    logic [ND-1:0]   r_wr;
    logic [ND-1:0]   r_sel;
    logic            r_sel_wr;
    logic [1:0]      r_grant;
    logic            r_busy;
    logic            r_terr;

    logic            w_a_pend;
    logic            w_b_pend;
    logic            w_pick_b;
    logic [NA-1:0]   w_a_wr_oh;
    logic [NA-1:0]   w_a_rd_oh;
    logic [NB-1:0]   w_b_wr_oh;
    logic [NB-1:0]   w_b_rd_oh;
    logic [NA-1:0]   w_a_cmd;
    logic [NB-1:0]   w_b_cmd;
    logic [ND-1:0]   w_sel;
    logic            w_sel_wr;
    logic [23:0]     w_cnt_nxt;
    logic            w_served_on;

    assign w_a_pend = (|a_rd) | (|a_wr);
    assign w_b_pend = (|b_rd) | (|b_wr);
    // On a tie the side that was not served last wins.
    assign w_pick_b = w_b_pend & (~w_a_pend | ~r_last_b);

    // x & -x isolates the lowest set bit.
    assign w_a_wr_oh = a_wr & (~a_wr + NA'(1'b1));
    assign w_a_rd_oh = a_rd & (~a_rd + NA'(1'b1));
    assign w_b_wr_oh = b_wr & (~b_wr + NB'(1'b1));
    assign w_b_rd_oh = b_rd & (~b_rd + NB'(1'b1));
    assign w_a_cmd   = (|a_wr) ? w_a_wr_oh : w_a_rd_oh;
    assign w_b_cmd   = (|b_wr) ? w_b_wr_oh : w_b_rd_oh;

    assign w_sel    = w_pick_b ? {w_b_cmd, {NA{1'b0}}} : {{NB{1'b0}}, w_a_cmd};
    assign w_sel_wr = w_pick_b ? (|b_wr) : (|a_wr);

    assign w_cnt_nxt   = (r_cnt == 24'hFF_FFFF) ? r_cnt : (r_cnt + 24'd1);
    // RELEASE waits for the requester to drop the exact bit that was served.
    assign w_served_on = |((r_sel_wr ? {b_wr, a_wr} : {b_rd, a_rd}) & r_sel);

    // Arbitration FSM with all channel-side outputs registered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= ST_IDLE;
            r_last_b <= 1'b1;
            r_cnt    <= 24'd0;
            r_lba    <= 32'd0;
            r_rd     <= {ND{1'b0}};
            r_wr     <= {ND{1'b0}};
            r_sel    <= {ND{1'b0}};
            r_sel_wr <= 1'b0;
            r_grant  <= 2'b00;
            r_busy   <= 1'b0;
            r_terr   <= 1'b0;
        end else begin
            r_terr <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_a_pend | w_b_pend) begin
                        r_lba    <= w_pick_b ? b_lba : a_lba;
                        r_rd     <= w_sel_wr ? {ND{1'b0}} : w_sel;
                        r_wr     <= w_sel_wr ? w_sel : {ND{1'b0}};
                        r_sel    <= w_sel;
                        r_sel_wr <= w_sel_wr;
                        r_grant  <= w_pick_b ? 2'b10 : 2'b01;
                        r_last_b <= w_pick_b;
                        r_cnt    <= 24'd0;
                        r_busy   <= 1'b1;
                        r_state  <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (sd_ack) begin
                        r_rd    <= {ND{1'b0}};
                        r_wr    <= {ND{1'b0}};
                        r_state <= ST_XFER;
                    end else if (w_cnt_nxt == TIMEOUT) begin
                        r_cnt   <= w_cnt_nxt;
                        r_rd    <= {ND{1'b0}};
                        r_wr    <= {ND{1'b0}};
                        r_grant <= 2'b00;
                        r_busy  <= 1'b0;
                        r_terr  <= 1'b1;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= w_cnt_nxt;
                    end
                end
                ST_XFER: begin
                    if (!sd_ack) begin
                        r_state <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    if (!w_served_on) begin
                        r_grant <= 2'b00;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_rd    <= {ND{1'b0}};
                    r_wr    <= {ND{1'b0}};
                    r_grant <= 2'b00;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign sd_lba      = r_lba;
    assign sd_rd       = r_rd;
    assign sd_wr       = r_wr;
    assign grant       = r_grant;
    assign busy        = r_busy;
    assign timeout_err = r_terr;

    assign a_ack     = sd_ack & r_grant[0];
    assign b_ack     = sd_ack & r_grant[1];
    assign a_buff_wr = sd_buff_wr & r_grant[0];
    assign b_buff_wr = sd_buff_wr & r_grant[1];

    // Write-data mux, zero-latency so data lines up with sd_buff_addr.
    always_comb begin
        sd_buff_din = 8'h00;
        case (r_grant)
            2'b01:   sd_buff_din = a_buff_din;
            2'b10:   sd_buff_din = b_buff_din;
            default: sd_buff_din = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_coco_sd_arbiter.sv
// Bench for coco_sd_arbiter: directed scenarios plus randomized traffic,
// all checked every cycle against a transaction-level reference model.
module tb_coco_sd_arbiter;

    localparam int          NA  = 4;
    localparam int          NB  = 2;
    localparam logic [23:0] TMO = 24'd16;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [31:0] a_lba = 32'd0, b_lba = 32'd0;
    logic [3:0]  a_rd = 4'd0, a_wr = 4'd0;
    logic [1:0]  b_rd = 2'd0, b_wr = 2'd0;
    logic [7:0]  a_buff_din = 8'd0, b_buff_din = 8'd0;
    logic        sd_ack = 1'b0, sd_buff_wr = 1'b0;
    logic        a_ack, a_buff_wr, b_ack, b_buff_wr;
    logic [31:0] sd_lba;
    logic [5:0]  sd_rd, sd_wr;
    logic [7:0]  sd_buff_din;
    logic [1:0]  grant;
    logic        busy, timeout_err;

    coco_sd_arbiter #(.NA(NA), .NB(NB), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset_n(reset_n),
        .a_lba(a_lba), .a_rd(a_rd), .a_wr(a_wr), .a_ack(a_ack),
        .a_buff_wr(a_buff_wr), .a_buff_din(a_buff_din),
        .b_lba(b_lba), .b_rd(b_rd), .b_wr(b_wr), .b_ack(b_ack),
        .b_buff_wr(b_buff_wr), .b_buff_din(b_buff_din),
        .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
        .sd_buff_wr(sd_buff_wr), .sd_buff_din(sd_buff_din),
        .grant(grant), .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    localparam int P_IDLE = 0, P_REQ = 1, P_XFER = 2, P_REL = 3;
    int          m_ph, m_cnt, m_drive;
    bit          m_last_b, m_is_wr, m_busy, m_terr;
    logic [31:0] m_lba;
    logic [5:0]  m_rd, m_wr;
    logic [1:0]  m_grant;

    task automatic model_reset();
        m_ph = P_IDLE; m_cnt = 0; m_drive = 0; m_last_b = 1'b1; m_is_wr = 1'b0;
        m_busy = 1'b0; m_terr = 1'b0; m_lba = 32'd0; m_rd = 6'd0; m_wr = 6'd0;
        m_grant = 2'b00;
    endtask

    task automatic model_step();
        logic [5:0] all_rd, all_wr;
        bit pa, pb, take_b, still;
        int lo, hi;
        all_rd = {b_rd, a_rd};
        all_wr = {b_wr, a_wr};
        m_terr = 1'b0;
        case (m_ph)
            P_IDLE: begin
                pa = (a_rd | a_wr) != 4'd0;
                pb = (b_rd | b_wr) != 2'd0;
                if (pa || pb) begin
                    take_b = pb && (!pa || !m_last_b);
                    lo = take_b ? NA : 0;
                    hi = take_b ? NA + NB - 1 : NA - 1;
                    m_drive = -1;
                    m_is_wr = 1'b0;
                    for (int i = lo; i <= hi; i++)
                        if (all_wr[i] && m_drive < 0) begin m_drive = i; m_is_wr = 1'b1; end
                    for (int i = lo; i <= hi; i++)
                        if (all_rd[i] && m_drive < 0) m_drive = i;
                    m_rd = 6'd0;
                    m_wr = 6'd0;
                    if (m_is_wr) m_wr[m_drive] = 1'b1;
                    else         m_rd[m_drive] = 1'b1;
                    m_lba    = take_b ? b_lba : a_lba;
                    m_grant  = take_b ? 2'b10 : 2'b01;
                    m_last_b = take_b;
                    m_cnt    = 0;
                    m_busy   = 1'b1;
                    m_ph     = P_REQ;
                end
            end
            P_REQ: begin
                if (sd_ack) begin
                    m_rd = 6'd0; m_wr = 6'd0; m_ph = P_XFER;
                end else begin
                    m_cnt++;
                    if (m_cnt == int'(TMO)) begin
                        m_terr = 1'b1; m_rd = 6'd0; m_wr = 6'd0;
                        m_grant = 2'b00; m_busy = 1'b0; m_ph = P_IDLE;
                    end
                end
            end
            P_XFER: if (!sd_ack) m_ph = P_REL;
            default: begin
                still = m_is_wr ? all_wr[m_drive] : all_rd[m_drive];
                if (!still) begin m_grant = 2'b00; m_busy = 1'b0; m_ph = P_IDLE; end
            end
        endcase
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) model_reset();
            else          model_step();
        end
    end

    // Every-cycle comparison of all DUT outputs against the model.
    always @(posedge clk) begin
        #2;
        if (chk_en) begin
            chk("m_sd_rd", sd_rd, m_rd);
            chk("m_sd_wr", sd_wr, m_wr);
            chk("m_sd_lba", sd_lba, m_lba);
            chk("m_grant", grant, m_grant);
            chk("m_busy", busy, m_busy);
            chk("m_timeout_err", timeout_err, m_terr);
            chk("m_a_ack", a_ack, sd_ack & m_grant[0]);
            chk("m_b_ack", b_ack, sd_ack & m_grant[1]);
            chk("m_a_buff_wr", a_buff_wr, sd_buff_wr & m_grant[0]);
            chk("m_b_buff_wr", b_buff_wr, sd_buff_wr & m_grant[1]);
            chk("m_sd_buff_din", sd_buff_din,
                (m_grant == 2'b01) ? a_buff_din : (m_grant == 2'b10) ? b_buff_din : 8'h00);
        end
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_grant(input logic [1:0] g, input string nm);
        int k = 0;
        while (grant !== g && k < 50) begin tick(); k++; end
        chk(nm, grant, g);
    endtask

    task automatic wait_idle(input string nm);
        int k = 0;
        while (busy !== 1'b0 && k < 80) begin tick(); k++; end
        chk(nm, busy, 1'b0);
    endtask

    int na, nb, kk;
    int h_st, h_wait, h_bytes, a_dly, b_dly;

    initial begin
        #1 reset_n = 1'b0;
        chk_en = 1'b1;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        tick();
        chk("rst_grant", grant, 2'b00);
        chk("rst_busy", busy, 1'b0);

        // Tie after reset: A first, then B, then A again.
        @(negedge clk); a_wr = 4'b0001; b_rd = 2'b01;
        tick();
        chk("tie1_sd_wr", sd_wr, 6'b000001);
        chk("tie1_grant", grant, 2'b01);
        @(negedge clk); sd_ack = 1'b1;
        tick();
        @(negedge clk); sd_ack = 1'b0; a_wr = 4'b0000;
        wait_grant(2'b10, "tie2_grant");
        chk("tie2_sd_rd", sd_rd, 6'b010000);
        @(negedge clk); sd_ack = 1'b1; a_wr = 4'b0001;
        tick();
        @(negedge clk); sd_ack = 1'b0; b_rd = 2'b00;
        wait_idle("tie2_idle");
        @(negedge clk); b_rd = 2'b01;
        tick();
        chk("tie3_grant", grant, 2'b01);
        chk("tie3_sd_wr", sd_wr, 6'b000001);
        @(negedge clk); sd_ack = 1'b1;
        tick();
        @(negedge clk); sd_ack = 1'b0; a_wr = 4'b0000; b_rd = 2'b00;
        wait_idle("tie3_idle");

        // Single read, A drive 2, 512 strobes.
        @(negedge clk); a_lba = 32'h123; a_rd = 4'b0100;
        tick();
        chk("rd_sd_rd", sd_rd, 6'b000100);
        chk("rd_sd_lba", sd_lba, 32'h123);
        chk("rd_grant", grant, 2'b01);
        chk("rd_busy", busy, 1'b1);
        @(negedge clk); sd_ack = 1'b1;
        tick();
        chk("rd_sd_rd_clr", sd_rd, 6'b000000);
        chk("rd_a_ack", a_ack, 1'b1);
        na = 0; nb = 0;
        for (int i = 0; i < 512; i++) begin
            @(negedge clk); sd_buff_wr = 1'b1;
            tick();
            if (a_buff_wr) na++;
            if (b_buff_wr) nb++;
            @(negedge clk); sd_buff_wr = 1'b0;
            tick();
        end
        chk("rd_a_strobes", na, 512);
        chk("rd_b_strobes", nb, 0);
        @(negedge clk); sd_ack = 1'b0; a_rd = 4'b0000;
        wait_idle("rd_idle");

        // Command selection: write beats read, lowest index.
        @(negedge clk); a_rd = 4'b1010; a_wr = 4'b0100;
        tick();
        chk("sel_sd_wr", sd_wr, 6'b000100);
        chk("sel_sd_rd", sd_rd, 6'b000000);
        @(negedge clk); sd_ack = 1'b1;
        tick();
        @(negedge clk); sd_ack = 1'b0; a_rd = 4'b0000; a_wr = 4'b0000;
        wait_idle("sel_idle");

        // Write data mux during a B write.
        @(negedge clk); a_buff_din = 8'hFF; b_buff_din = 8'h5A;
        tick();
        chk("mux_idle_pre", sd_buff_din, 8'h00);
        @(negedge clk); b_wr = 2'b01;
        tick();
        chk("mux_grant", grant, 2'b10);
        chk("mux_sd_wr", sd_wr, 6'b010000);
        @(negedge clk); sd_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("mux_xfer", sd_buff_din, 8'h5A);
        end
        @(negedge clk); sd_ack = 1'b0; b_wr = 2'b00;
        wait_idle("mux_idle");
        chk("mux_idle_post", sd_buff_din, 8'h00);

        // Timeout: pulse exactly TIMEOUT cycles after the grant, then re-grant.
        @(negedge clk); a_rd = 4'b0001;
        tick();
        chk("tmo_grant", grant, 2'b01);
        kk = 0;
        for (int k = 1; k <= 24; k++) begin
            if (kk == 0) begin
                tick();
                if (timeout_err) kk = k;
            end
        end
        chk("tmo_cycle", kk, 16);
        chk("tmo_sd_rd", sd_rd, 6'b000000);
        chk("tmo_grant_clr", grant, 2'b00);
        tick();
        chk("tmo_regrant", grant, 2'b01);
        chk("tmo_single_pulse", timeout_err, 1'b0);
        @(negedge clk); a_rd = 4'b0000;
        wait_idle("tmo_idle");

        // Reset during the 100th strobe of an A read with B pending.
        @(negedge clk); a_rd = 4'b0001;
        tick();
        @(negedge clk); b_rd = 2'b01; sd_ack = 1'b1;
        tick();
        for (int i = 0; i < 99; i++) begin
            @(negedge clk); sd_buff_wr = 1'b1;
            tick();
            @(negedge clk); sd_buff_wr = 1'b0;
            tick();
        end
        @(negedge clk); sd_buff_wr = 1'b1;
        #2;
        chk("rst_pre_bwr", a_buff_wr, 1'b1);
        reset_n = 1'b0;
        #1;
        chk("rst_async_grant", grant, 2'b00);
        chk("rst_async_busy", busy, 1'b0);
        chk("rst_async_a_ack", a_ack, 1'b0);
        chk("rst_async_a_bwr", a_buff_wr, 1'b0);
        chk("rst_async_lba", sd_lba, 32'd0);
        chk("rst_async_cmd", {sd_rd, sd_wr}, 12'd0);
        a_rd = 4'b0000; sd_ack = 1'b0; sd_buff_wr = 1'b0;
        @(negedge clk); reset_n = 1'b1;
        tick();
        chk("rst_b_grant", grant, 2'b10);
        chk("rst_b_sd_rd", sd_rd, 6'b010000);
        @(negedge clk); sd_ack = 1'b1;
        tick();
        @(negedge clk); sd_ack = 1'b0; b_rd = 2'b00;
        wait_idle("rst_idle");

        // Randomized traffic with a behavioural host and two requesters.
        h_st = 0; h_wait = 0; h_bytes = 0; a_dly = -1; b_dly = -1;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            case (h_st)
                0: if ((sd_rd | sd_wr) != 6'd0) begin
                       h_wait = $urandom_range(1, 20); h_st = 1;
                   end
                1: if ((sd_rd | sd_wr) == 6'd0) h_st = 0;
                   else begin
                       h_wait--;
                       if (h_wait == 0) begin
                           sd_ack = 1'b1; h_bytes = $urandom_range(1, 6); h_st = 2;
                       end
                   end
                2: begin
                       sd_buff_wr = 1'($urandom_range(0, 1));
                       if (sd_buff_wr) h_bytes--;
                       if (h_bytes == 0) h_st = 3;
                   end
                default: begin sd_buff_wr = 1'b0; sd_ack = 1'b0; h_st = 0; end
            endcase
            if (a_ack && a_dly < 0) a_dly = $urandom_range(0, 3);
            if (a_dly == 0) begin a_rd = 4'd0; a_wr = 4'd0; a_dly = -1; end
            else if (a_dly > 0) a_dly--;
            if (b_ack && b_dly < 0) b_dly = $urandom_range(0, 3);
            if (b_dly == 0) begin b_rd = 2'd0; b_wr = 2'd0; b_dly = -1; end
            else if (b_dly > 0) b_dly--;
            if (a_rd == 4'd0 && a_wr == 4'd0 && a_dly < 0 && $urandom_range(0, 7) == 0) begin
                a_rd = 4'($urandom);
                a_wr = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'd0;
            end
            if (b_rd == 2'd0 && b_wr == 2'd0 && b_dly < 0 && $urandom_range(0, 7) == 0) begin
                b_rd = 2'($urandom);
                b_wr = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'd0;
            end
            if (grant != 2'b01 && a_dly < 0 && $urandom_range(0, 31) == 0) a_rd = 4'($urandom);
            if (grant != 2'b10 && b_dly < 0 && $urandom_range(0, 31) == 0) b_rd = 2'($urandom);
            a_lba = $urandom; b_lba = $urandom;
            a_buff_din = 8'($urandom); b_buff_din = 8'($urandom);
        end
        @(negedge clk);
        a_rd = 4'd0; a_wr = 4'd0; b_rd = 2'd0; b_wr = 2'd0;
        sd_ack = 1'b0; sd_buff_wr = 1'b0;
        wait_idle("rand_idle");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
